// File: rtl/fifo_pkg.sv
// fifo_pkg: constants and small helpers shared by the synchronous FIFO and its reader.
// Contents: default word width/depth, occupancy type, pop-credit helper.
// No macros; no state.
package fifo_pkg;

  // Default geometry of the team FIFO; the reader's WIDTH must match the FIFO it drains.
  localparam int FIFO_WIDTH = 16;
  localparam int FIFO_DEPTH = 8;

  // Number of slots in the reader's output buffer.
  localparam int RD_BUF_SLOTS = 2;

  // Occupancy of the reader output buffer (0..2).
  typedef logic [1:0] occ_t;

  // Words committed to the buffer after this edge: held + arriving - leaving.
  // Three bits so an (illegal) overflow past 2 stays visible to the checker.
  function automatic logic [2:0] occ_after(input occ_t count, input logic pend, input logic fire);
    return {1'b0, count} + {2'b00, pend} - {2'b00, fire};
  endfunction

  // A new pop may be issued only if the popped word is guaranteed a slot when it lands.
  function automatic logic pop_credit(input occ_t count, input logic pend, input logic fire);
    return occ_after(count, pend, fire) < 3'(RD_BUF_SLOTS);
  endfunction

endpackage

// File: rtl/fifo_reader_if.sv
// fifo_reader_if: FIFO pop port plus downstream valid/ready stream, as seen by the reader.
// Signals: empty_bar/fifo_data/get (FIFO side), m_valid/m_ready/m_data (stream side).
// master = the reader; slave = FIFO + consumer environment.
interface fifo_reader_if #(
  parameter int WIDTH = fifo_pkg::FIFO_WIDTH
);

  logic             empty_bar;
  logic [WIDTH-1:0] fifo_data;
  logic             get;
  logic             m_valid;
  logic             m_ready;
  logic [WIDTH-1:0] m_data;

  modport master (
    input  empty_bar,
    input  fifo_data,
    input  m_ready,
    output get,
    output m_valid,
    output m_data
  );

  modport slave (
    output empty_bar,
    output fifo_data,
    output m_ready,
    input  get,
    input  m_valid,
    input  m_data
  );

endinterface

// File: rtl/fifo_reader_buf.sv
// fifo_reader_buf: 2-entry in-order output buffer; head is registered and drives the stream.
// Latency: a word written at edge N is at the head (or behind it) from N+1.
// Backpressure: never refuses a write; the caller's credit rule keeps it from overflowing.
// Ports: clk, rst (async, active-high), wr_en_i/wr_dat_i (write), fire_i (head consumed),
//        count_o (0..2 entries held), head_o (buf0 contents).
module fifo_reader_buf
  import fifo_pkg::*;
#(
  parameter int WIDTH = FIFO_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en_i,
  input  logic [WIDTH-1:0] wr_dat_i,
  input  logic             fire_i,
  output occ_t             count_o,
  output logic [WIDTH-1:0] head_o
);

  occ_t             count_q, count_d;
  logic [WIDTH-1:0] buf0_q, buf0_d;
  logic [WIDTH-1:0] buf1_q, buf1_d;
  logic [2:0]       occ_sum;
  occ_t             kept;

  // Entries surviving this edge's pop; decides which slot the incoming word takes.
  assign kept    = count_q - occ_t'(fire_i);
  assign occ_sum = occ_after(count_q, wr_en_i, fire_i);

  always_comb begin
    count_d = occ_sum[1:0];
    buf0_d  = buf0_q;
    buf1_d  = buf1_q;

    // Shift first, then the new word fills the first free slot behind the survivors.
    if (fire_i) begin
      buf0_d = buf1_q;
    end
    if (wr_en_i) begin
      if (kept == 2'd0) begin
        buf0_d = wr_dat_i;
      end else begin
        buf1_d = wr_dat_i;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
      buf0_q  <= '0;
      buf1_q  <= '0;
    end else begin
      count_q <= count_d;
      buf0_q  <= buf0_d;
      buf1_q  <= buf1_d;
    end
  end

  assign count_o = count_q;
  assign head_o  = buf0_q;

  // Overflow would mean the upstream credit logic let an extra word in.
  a_no_overflow: assert property (@(posedge clk) disable iff (rst) occ_sum <= 3'd2);

endmodule

// File: rtl/fifo_reader.sv
// fifo_reader: drains the team FIFO pop port into a registered valid/ready stream.
// Latency: 2 cycles from first pop (get) to m_valid; 1 word/cycle sustained.
// Backpressure: m_ready low lets at most 2 more pops land, then get holds 0 until fire.
// Ports: clk, reset (async, active-high), bus (fifo_reader_if.master: empty_bar, fifo_data,
//        get, m_valid, m_ready, m_data), words_read (delivered-word count, optional).
// Optional feature: define FIFO_READER_CNT_EN to add the words_read port and counter.
module fifo_reader
  import fifo_pkg::*;
#(
  parameter int WIDTH     = FIFO_WIDTH,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  fifo_reader_if.master        bus
`ifdef FIFO_READER_CNT_EN
  ,
  output logic [CNT_WIDTH-1:0] words_read
`endif
);

  if (WIDTH < 1 || CNT_WIDTH < 1) begin : g_bad_param
    $error("fifo_reader: WIDTH and CNT_WIDTH must be at least 1");
  end

  occ_t             count;
  logic [WIDTH-1:0] head;
  logic             fire;
  logic             pend_q, pend_d;
  logic             get;

  // Stream outputs come straight from buffer registers: no path from fifo_data.
  assign bus.m_valid = (count != 2'd0);
  assign bus.m_data  = head;
  assign fire        = bus.m_valid & bus.m_ready;

  // m_ready feeds get combinationally so a pop can be issued in the same cycle a slot frees.
  // Forced low during reset so the FIFO never pops a word the reader would discard.
  assign get     = ~reset & bus.empty_bar & pop_credit(count, pend_q, fire);
  assign bus.get = get;

  // The popped word shows up on fifo_data next cycle; pend marks that it must be captured.
  assign pend_d = get;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend_q <= 1'b0;
    end else begin
      pend_q <= pend_d;
    end
  end

  fifo_reader_buf #(
    .WIDTH (WIDTH)
  ) u_buf (
    .clk      (clk),
    .rst      (reset),
    .wr_en_i  (pend_q),
    .wr_dat_i (bus.fifo_data),
    .fire_i   (fire),
    .count_o  (count),
    .head_o   (head)
  );

`ifdef FIFO_READER_CNT_EN
  logic [CNT_WIDTH-1:0] words_read_q, words_read_d;

  // Wraps naturally at 2^CNT_WIDTH.
  assign words_read_d = fire ? words_read_q + CNT_WIDTH'(1) : words_read_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      words_read_q <= '0;
    end else begin
      words_read_q <= words_read_d;
    end
  end

  assign words_read = words_read_q;
`endif

endmodule

// File: tb/tb_fifo_reader.sv
// tb_fifo_reader: randomized bench for fifo_reader against a queue-based FIFO + stream model.
// Latency: checks first m_valid 2 cycles after first get and gap-free bursts.
// Backpressure: random and held m_ready stalls; outputs compared every cycle.
module tb_fifo_reader;
  import fifo_pkg::*;

  localparam int W  = 16;
  localparam int CW = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  fifo_reader_if #(.WIDTH(W)) bus ();

`ifdef FIFO_READER_CNT_EN
  logic [CW-1:0] words_read;
`endif

  fifo_reader #(
    .WIDTH     (W),
    .CNT_WIDTH (CW)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
`ifdef FIFO_READER_CNT_EN
    ,
    .words_read (words_read)
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;

  // FIFO contents, words expected in delivery order, and words the reader should be holding.
  logic [W-1:0] fifo_q[$];
  logic [W-1:0] ref_q[$];
  logic [W-1:0] held_q[$];
  bit           inflight;
  logic [W-1:0] inflight_word;

  int cyc = 0;
  int n_get, n_fire, n_push, first_get, first_vld, first_fire, last_fire;
  int fire_total = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic clear_stats();
    n_get = 0; n_fire = 0; n_push = 0;
    first_get = -1; first_vld = -1; first_fire = -1; last_fire = -1;
  endtask

  task automatic preload(input logic [W-1:0] v);
    fifo_q.push_back(v);
    ref_q.push_back(v);
    n_push++;
  endtask

  // One clock cycle: drive inputs, compare outputs to the model, then advance the model.
  task automatic cycle(input bit rdy, input bit push, input logic [W-1:0] val);
    bit exp_vld, exp_get, mfire, dfire;
    int outstanding;
    @(negedge clk);
    if (push && fifo_q.size() < FIFO_DEPTH) preload(val);
    bus.m_ready   = rdy;
    bus.empty_bar = (fifo_q.size() != 0);
    #1;
    exp_vld     = (held_q.size() != 0);
    mfire       = exp_vld && rdy;
    outstanding = held_q.size() + (inflight ? 1 : 0) - (mfire ? 1 : 0);
    exp_get     = bus.empty_bar && (outstanding < 2);
    chk("m_valid", 32'(bus.m_valid), 32'(exp_vld));
    if (exp_vld) chk("m_data", 32'(bus.m_data), 32'(held_q[0]));
    chk("get", 32'(bus.get), 32'(exp_get));
`ifdef FIFO_READER_CNT_EN
    chk("words_read", 32'(words_read), 32'(fire_total % (1 << CW)));
`endif
    dfire = bus.m_valid && rdy;
    if (bus.get) begin
      n_get++;
      if (first_get < 0) first_get = cyc;
    end
    if (bus.m_valid && first_vld < 0) first_vld = cyc;
    if (dfire) begin
      n_fire++;
      if (first_fire < 0) first_fire = cyc;
      last_fire = cyc;
    end
    if (mfire) begin
      if (ref_q.size() == 0) chk("spurious_word", 32'(bus.m_data), 32'hFFFF_FFFF);
      else chk("order", 32'(bus.m_data), 32'(ref_q.pop_front()));
      void'(held_q.pop_front());
      fire_total++;
    end
    if (inflight) held_q.push_back(inflight_word);
    inflight = 1'b0;
    if (bus.get && bus.empty_bar) begin
      inflight      = 1'b1;
      inflight_word = fifo_q.pop_front();
    end
    @(posedge clk);
    #1;
    if (inflight) bus.fifo_data = inflight_word;
    cyc++;
  endtask

  // Reset asserted in the middle of the low clock phase; FIFO model is emptied alongside.
  task automatic reset_mid();
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk("rst_m_valid", 32'(bus.m_valid), 32'd0);
    chk("rst_get", 32'(bus.get), 32'd0);
    chk("rst_m_data", 32'(bus.m_data), 32'd0);
`ifdef FIFO_READER_CNT_EN
    chk("rst_words_read", 32'(words_read), 32'd0);
`endif
    fifo_q.delete(); ref_q.delete(); held_q.delete();
    inflight = 1'b0; fire_total = 0;
    bus.empty_bar = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    logic [W-1:0] pat;
    bit           saw_full;
    reset         = 1'b1;
    bus.empty_bar = 1'b1;
    bus.m_ready   = 1'b0;
    bus.fifo_data = '0;
    inflight      = 1'b0;
    clear_stats();
    #3;
    // get must stay low under reset even with a non-empty FIFO.
    chk("reset_get", 32'(bus.get), 32'd0);
    chk("reset_m_valid", 32'(bus.m_valid), 32'd0);
    chk("reset_m_data", 32'(bus.m_data), 32'd0);
`ifdef FIFO_READER_CNT_EN
    chk("reset_words_read", 32'(words_read), 32'd0);
`endif
    bus.empty_bar = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Basic transfer: 8 preloaded words, consumer always ready.
    clear_stats();
    for (int i = 1; i <= 8; i++) preload(W'(i));
    repeat (14) cycle(1'b1, 1'b0, '0);
    chk("basic_latency", 32'(first_vld - first_get), 32'd2);
    chk("basic_burst", 32'(last_fire - first_fire), 32'd7);
    chk("basic_words", 32'(n_fire), 32'd8);
    chk("basic_gets", 32'(n_get), 32'd8);

    // Backpressure: consumer stalled, only two pops may be issued.
    clear_stats();
    for (int i = 1; i <= 8; i++) preload(W'(i));
    repeat (6) cycle(1'b0, 1'b0, '0);
    chk("bp_gets", 32'(n_get), 32'd2);
    chk("bp_valid", 32'(bus.m_valid), 32'd1);
    chk("bp_head", 32'(bus.m_data), 32'h0001);
    repeat (16) cycle(1'b1, 1'b0, '0);
    chk("bp_words", 32'(n_fire), 32'd8);
    chk("bp_gets_total", 32'(n_get), 32'd8);

    // Random stalls with a continuously refilled FIFO.
    clear_stats();
    pat = 16'h0100;
    saw_full = 1'b0;
    for (int i = 0; i < 600; i++) begin
      bit p;
      p = ($urandom_range(3) != 0);
      if (p && fifo_q.size() < FIFO_DEPTH) begin
        cycle(1'($urandom_range(1)), 1'b1, pat);
        pat++;
      end else begin
        if (fifo_q.size() >= FIFO_DEPTH) saw_full = 1'b1;
        cycle(1'($urandom_range(1)), 1'b0, '0);
      end
    end
    repeat (30) cycle(1'b1, 1'b0, '0);
    chk("rand_all_delivered", 32'(n_fire), 32'(n_push));
    chk("rand_ref_empty", 32'(ref_q.size()), 32'd0);
    chk("rand_fifo_filled", 32'(saw_full), 32'd1);

    // Reset while streaming (a word in flight and one buffered), then a fresh load.
    for (int i = 0; i < 8; i++) preload(W'(16'h0010 + i));
    repeat (4) cycle(1'b1, 1'b0, '0);
    reset_mid();
    clear_stats();
    for (int i = 0; i < 4; i++) preload(W'(16'h00A0 + i));
    repeat (12) cycle(1'($urandom_range(1)), 1'b0, '0);
    repeat (8) cycle(1'b1, 1'b0, '0);
    chk("post_rst_words", 32'(n_fire), 32'd4);
    chk("post_rst_gets", 32'(n_get), 32'd4);
    chk("post_rst_idle", 32'(bus.m_valid), 32'd0);

    // 17 deliveries: a 4-bit delivered-word counter wraps to 1.
    reset_mid();
    clear_stats();
    pat = 16'h0200;
    for (int i = 0; i < 40; i++) begin
      if (n_push < 17 && fifo_q.size() < FIFO_DEPTH) begin
        cycle(1'b1, 1'b1, pat);
        pat++;
      end else begin
        cycle(1'b1, 1'b0, '0);
      end
    end
    chk("cnt_words", 32'(n_fire), 32'd17);
`ifdef FIFO_READER_CNT_EN
    chk("cnt_wrap", 32'(words_read), 32'd1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
